sha512_pad: RTL and testbench
=============================

SHA512_PAD -- requirements
Module: sha512_pad

Interface
REQ-001 The block SHALL have no parameters; word type is the 64-bit SHA word, FIFO entry is {data[63:0], mask[7:0]}.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 sha_en_i  in  1  engine enable; low forces abort to idle.
REQ-005 hash_start_i  in  1  single-cycle pulse, begins a new message.
REQ-006 hash_process_i  in  1  single-cycle pulse, no more message data follows.
REQ-007 message_length_i  in  128  total message length in bits, stable from hash_process_i until hash_done_o.
REQ-008 fifo_rvalid_i  in  1  message FIFO head valid.
REQ-009 fifo_rdata_i  in  72  FIFO head {data[63:0], mask[7:0]}; mask[7] covers data[63:56], mask[0] covers data[7:0].
REQ-010 fifo_rready_o  out  1  pop FIFO head.
REQ-011 shaf_rvalid_o  out  1  padded word valid to compression core.
REQ-012 shaf_rdata_o  out  64  padded word.
REQ-013 shaf_rready_i  in  1  compression core accepts word.
REQ-014 hash_done_o  out  1  one-cycle pulse after the final length word is accepted.

Function
REQ-015 A word transfer SHALL occur on a cycle with shaf_rvalid_o && shaf_rready_i; shaf_rdata_o SHALL be stable while valid and not ready.
REQ-016 A 4-bit word counter SHALL increment mod 16 on every transfer and clear on hash_start_i.
REQ-017 States SHALL be Idle, FifoRx, Pad80, Pad00, LenHi, LenLo.
REQ-018 Idle: shaf_rvalid_o=0, fifo_rready_o=0; hash_start_i with sha_en_i=1 -> FifoRx.
REQ-019 hash_process_i SHALL be latched into a process flag, cleared on entering Idle.
REQ-020 FifoRx with full mask (8'hFF): shaf_rvalid_o=fifo_rvalid_i, shaf_rdata_o=data, fifo_rready_o=shaf_rready_i; stay.
REQ-021 FifoRx with partial mask (leading-contiguous ones, k valid bytes, 0<k<8): output data with byte k (bits [63-8k -: 8]) = 8'h80 and bytes below it zero; on transfer pop FIFO -> Pad00.
REQ-022 FifoRx with process flag set and fifo_rvalid_i=0 -> Pad80 (FIFO drained with only full words).
REQ-023 Pad80: output 64'h8000_0000_0000_0000; on transfer -> Pad00.
REQ-024 Pad00: if counter==14 -> LenHi without output; else output zero word, remain until counter==14 (wrapping through 15,0 starts a second block).
REQ-025 LenHi: output message_length_i[127:64]; LenLo: output message_length_i[63:0]; LenLo transfer -> Idle and hash_done_o=1 next cycle.
REQ-026 fifo_rready_o SHALL be 0 in every state except FifoRx.
REQ-027 Mask 8'h00 in FifoRx SHALL be treated as k=0: output 64'h8000_0000_0000_0000, pop, -> Pad00.
REQ-028 sha_en_i=0 in any state SHALL force Idle next cycle, clear counter and process flag, no hash_done_o.
REQ-029 hash_start_i outside Idle SHALL be ignored.
REQ-030 hash_process_i coinciding with hash_start_i SHALL be latched (zero-length message).
REQ-031 Total output per message SHALL be a multiple of 16 words.

Reset
REQ-032 With rst_i=1 at a clock edge: state=Idle, counter=0, process flag=0, shaf_rvalid_o=0, fifo_rready_o=0, hash_done_o=0.
REQ-033 Reset mid-message SHALL discard all progress; FIFO contents are not popped by reset.

Verification
REQ-034 Empty msg: start+process same cycle, length=0, ready=1 -> 64'h8000..0, 13 zero words, 64'h0, 64'h0 (16 words), done pulse.
REQ-035 "abc": one entry 64'h6162_6300_0000_0000 mask 8'hE0, length=24 -> 64'h6162_6380_0000_0000, 13 zeros, 64'h0, 64'h18.
REQ-036 14 full words, length=896 -> 14 data words, 0x80 word at index 14, 15 zeros, 64'h0, 64'h380 (32 words total).
REQ-037 Random shaf_rready_i stalls on REQ-035 -> identical word sequence, data stable during stall, one pop per transferred FIFO word.
REQ-038 sha_en_i dropped during Pad00 -> Idle next cycle, no done; subsequent "abc" run yields REQ-035 output.
REQ-039 rst_i asserted in LenHi -> all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/sha512_pad.sv
// rtl/sha512_pad.sv - SHA-512 message padder between the message FIFO and the compression core
// Adds the 0x80 marker, zero fill and the 128-bit length, keeping each message a whole number of 16-word blocks.

module sha512_pad (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         sha_en_i,
   input  logic         hash_start_i,
   input  logic         hash_process_i,
   input  logic [127:0] message_length_i,
   input  logic         fifo_rvalid_i,
   input  logic [71:0]  fifo_rdata_i,
   output logic         fifo_rready_o,
   output logic         shaf_rvalid_o,
   output logic [63:0]  shaf_rdata_o,
   input  logic         shaf_rready_i,
   output logic         hash_done_o
);

   typedef enum logic [2:0] {
      IDLE,
      FIFO_RX,
      PAD80,
      PAD00,
      LEN_HI,
      LEN_LO
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  word_cnt_q;
   logic        process_q;
   logic        done_q;
   logic [63:0] fifo_data;
   logic [7:0]  fifo_mask;
   logic [3:0]  valid_bytes;
   logic [63:0] partial_word;
   logic        xfer;

   assign fifo_data = fifo_rdata_i[71:8];
   assign fifo_mask = fifo_rdata_i[7:0];

   // Valid bytes are leading-contiguous from the MSB; 8 means a full word.
   always_comb begin
      valid_bytes = 4'd8;
      casez (fifo_mask)
         8'b0???????: valid_bytes = 4'd0;
         8'b10??????: valid_bytes = 4'd1;
         8'b110?????: valid_bytes = 4'd2;
         8'b1110????: valid_bytes = 4'd3;
         8'b11110???: valid_bytes = 4'd4;
         8'b111110??: valid_bytes = 4'd5;
         8'b1111110?: valid_bytes = 4'd6;
         8'b11111110: valid_bytes = 4'd7;
         default:     valid_bytes = 4'd8;
      endcase
   end

   always_comb begin
      partial_word = 64'h0;
      for (int b = 0; b < 8; b++) begin
         if (4'(b) < valid_bytes) begin
            partial_word[63-8*b -: 8] = fifo_data[63-8*b -: 8];
         end else if (4'(b) == valid_bytes) begin
            partial_word[63-8*b -: 8] = 8'h80;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      shaf_rvalid_o = 1'b0;
      shaf_rdata_o  = 64'h0;
      fifo_rready_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (hash_start_i) state_d = FIFO_RX;
         end
         FIFO_RX: begin
            if (fifo_rvalid_i) begin
               shaf_rvalid_o = 1'b1;
               fifo_rready_o = shaf_rready_i;
               if (fifo_mask == 8'hFF) begin
                  shaf_rdata_o = fifo_data;
               end else begin
                  shaf_rdata_o = partial_word;
                  if (shaf_rready_i) state_d = PAD00;
               end
            end else if (process_q) begin
               state_d = PAD80;
            end
         end
         PAD80: begin
            shaf_rvalid_o = 1'b1;
            shaf_rdata_o  = 64'h8000_0000_0000_0000;
            if (shaf_rready_i) state_d = PAD00;
         end
         PAD00: begin
            // Word 14 of the current block is where the length goes.
            if (word_cnt_q == 4'd14) begin
               state_d = LEN_HI;
            end else begin
               shaf_rvalid_o = 1'b1;
            end
         end
         LEN_HI: begin
            shaf_rvalid_o = 1'b1;
            shaf_rdata_o  = message_length_i[127:64];
            if (shaf_rready_i) state_d = LEN_LO;
         end
         LEN_LO: begin
            shaf_rvalid_o = 1'b1;
            shaf_rdata_o  = message_length_i[63:0];
            if (shaf_rready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Disabling the engine suppresses any handshake in the aborting cycle.
      if (!sha_en_i) begin
         state_d       = IDLE;
         shaf_rvalid_o = 1'b0;
         fifo_rready_o = 1'b0;
      end
   end

   assign xfer        = shaf_rvalid_o && shaf_rready_i;
   assign hash_done_o = done_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         word_cnt_q <= 4'd0;
         process_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == LEN_LO) && xfer;
         if (state_d == IDLE) begin
            process_q <= 1'b0;
         end else if (hash_process_i) begin
            process_q <= 1'b1;
         end
         if (!sha_en_i || (state_q == IDLE && hash_start_i)) begin
            word_cnt_q <= 4'd0;
         end else if (xfer) begin
            word_cnt_q <= word_cnt_q + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sha512_pad.sv
// tb/tb_sha512_pad.sv - scoreboard bench for sha512_pad
// A FIFO model feeds the padder; expected words come from a byte-level padding model.

module tb_sha512_pad;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         sha_en_i = 1'b1;
   logic         hash_start_i = 1'b0;
   logic         hash_process_i = 1'b0;
   logic [127:0] message_length_i = 128'h0;
   logic         fifo_rvalid_i = 1'b0;
   logic [71:0]  fifo_rdata_i = 72'h0;
   logic         fifo_rready_o;
   logic         shaf_rvalid_o;
   logic [63:0]  shaf_rdata_o;
   logic         shaf_rready_i = 1'b1;
   logic         hash_done_o;

   int           errors = 0;
   int           checks = 0;
   int           words_seen = 0;
   int           words_base = 0;
   int           pops = 0;
   logic         pop_req = 1'b0;
   logic         rand_ready = 1'b0;
   logic         stall_chk = 1'b0;
   logic         held_valid = 1'b0;
   logic [63:0]  held_data = 64'h0;
   logic [71:0]  fifo_q[$];
   logic [71:0]  msg_q[$];
   logic [63:0]  exp_q[$];

   sha512_pad dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .sha_en_i         (sha_en_i),
      .hash_start_i     (hash_start_i),
      .hash_process_i   (hash_process_i),
      .message_length_i (message_length_i),
      .fifo_rvalid_i    (fifo_rvalid_i),
      .fifo_rdata_i     (fifo_rdata_i),
      .fifo_rready_o    (fifo_rready_o),
      .shaf_rvalid_o    (shaf_rvalid_o),
      .shaf_rdata_o     (shaf_rdata_o),
      .shaf_rready_i    (shaf_rready_i),
      .hash_done_o      (hash_done_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Byte-level padding model: message bytes, 0x80, zeros to 112 mod 128, 16-byte length.
   task automatic push_expected(input logic [127:0] len);
      logic [7:0]  bytes[$];
      logic [71:0] e;
      logic [63:0] w;
      foreach (msg_q[i]) begin
         e = msg_q[i];
         for (int b = 0; b < 8; b++)
            if (e[7-b]) bytes.push_back(e[71-8*b -: 8]);
      end
      bytes.push_back(8'h80);
      while ((bytes.size() % 128) != 112) bytes.push_back(8'h00);
      for (int b = 15; b >= 0; b--) bytes.push_back(len[8*b +: 8]);
      for (int k = 0; k < bytes.size() / 8; k++) begin
         w = 64'h0;
         for (int b = 0; b < 8; b++) w = {w[55:0], bytes[8*k+b]};
         exp_q.push_back(w);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (pop_req) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_req = 1'b0;
      end
      fifo_rvalid_i = (fifo_q.size() != 0);
      fifo_rdata_i  = fifo_rvalid_i ? fifo_q[0] : 72'h0;
      if (rand_ready) shaf_rready_i = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (fifo_rvalid_i && fifo_rready_o) begin
         pop_req = 1'b1;
         pops++;
      end
      if (stall_chk && held_valid && shaf_rvalid_o)
         check_val("stall_stable", 128'(shaf_rdata_o), 128'(held_data));
      held_valid = shaf_rvalid_o && !shaf_rready_i;
      held_data  = shaf_rdata_o;
      if (shaf_rvalid_o && shaf_rready_i) begin
         check_val("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0)
            check_val($sformatf("word%0d", words_seen - words_base),
                      128'(shaf_rdata_o), 128'(exp_q.pop_front()));
         words_seen++;
      end
   end

   task automatic start_msg(input logic [127:0] len, input logic same_cycle);
      push_expected(len);
      foreach (msg_q[i]) fifo_q.push_back(msg_q[i]);
      message_length_i = len;
      words_base = words_seen;
      pops = 0;
      repeat (2) @(posedge clk);
      #1;
      hash_start_i   = 1'b1;
      hash_process_i = same_cycle;
      @(posedge clk);
      #1;
      hash_start_i   = 1'b0;
      hash_process_i = !same_cycle;
      @(posedge clk);
      #1;
      hash_process_i = 1'b0;
   endtask

   task automatic finish_msg(input string name, input int exp_words, input int exp_pops);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         if (hash_done_o) seen = 1'b1;
      end
      check_val({name, "_done"}, 128'(seen), 128'd1);
      check_val({name, "_sb_drained"}, 128'(exp_q.size()), 128'd0);
      check_val({name, "_nwords"}, 128'(words_seen - words_base), 128'(exp_words));
      check_val({name, "_mod16"}, 128'((words_seen - words_base) % 16), 128'd0);
      check_val({name, "_pops"}, 128'(pops), 128'(exp_pops));
      @(negedge clk);
      check_val({name, "_done_pulse"}, 128'(hash_done_o), 128'd0);
      exp_q.delete();
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 400 && (words_seen - words_base) < n; i++) begin
         @(posedge clk);
         #1;
      end
      check_val("reach_words", 128'(words_seen - words_base >= n), 128'd1);
   endtask

   task automatic load_abc();
      msg_q.delete();
      msg_q.push_back({64'h6162_6300_0000_0000, 8'hE0});
   endtask

   initial begin
      int done_cnt;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check_val("rst_rvalid", 128'(shaf_rvalid_o), 128'd0);
      check_val("rst_fifo_rready", 128'(fifo_rready_o), 128'd0);
      check_val("rst_done", 128'(hash_done_o), 128'd0);

      msg_q.delete();
      start_msg(128'd0, 1'b1);
      finish_msg("empty", 16, 0);

      load_abc();
      start_msg(128'd24, 1'b0);
      finish_msg("abc", 16, 1);

      msg_q.delete();
      for (int i = 0; i < 14; i++) msg_q.push_back({$urandom(), $urandom(), 8'hFF});
      start_msg(128'd896, 1'b0);
      finish_msg("w14", 32, 14);

      load_abc();
      rand_ready = 1'b1;
      stall_chk  = 1'b1;
      start_msg(128'd24, 1'b0);
      finish_msg("abc_stall", 16, 1);
      rand_ready = 1'b0;
      stall_chk  = 1'b0;
      @(posedge clk);
      #2;
      shaf_rready_i = 1'b1;

      load_abc();
      start_msg(128'd24, 1'b0);
      wait_words(4);
      sha_en_i = 1'b0;
      @(posedge clk);
      #1;
      sha_en_i = 1'b1;
      exp_q.delete();
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) check_val("abort_rvalid", 128'(shaf_rvalid_o), 128'd0);
         if (hash_done_o) done_cnt++;
      end
      check_val("abort_no_done", 128'(done_cnt), 128'd0);

      load_abc();
      start_msg(128'd24, 1'b0);
      finish_msg("abc_after_abort", 16, 1);

      load_abc();
      start_msg(128'd24, 1'b0);
      wait_words(14);
      shaf_rready_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("lenhi_rvalid", 128'(shaf_rvalid_o), 128'd1);
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      exp_q.delete();
      shaf_rready_i = 1'b1;
      @(negedge clk);
      check_val("rst_lenhi_rvalid", 128'(shaf_rvalid_o), 128'd0);
      check_val("rst_lenhi_rdata", 128'(shaf_rdata_o), 128'd0);
      check_val("rst_lenhi_fifo_rready", 128'(fifo_rready_o), 128'd0);
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (hash_done_o) done_cnt++;
      end
      check_val("rst_no_done", 128'(done_cnt), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
